// File: rtl/types_pkg.sv
// types_pkg: shared time-of-day types, timing constants and converter FSM states.
// Contents:
//   time_t        - packed BCD hh:mm:ss.mmm, one 4-bit digit per field, most significant first
//   SEC_PER_*     - seconds per day, hour and minute
//   tod_state_t   - states of the binary-to-BCD time-of-day converter
package types_pkg;
  typedef struct packed {
    logic [3:0] t_10h, t_1h, t_10m, t_1m, t_10s, t_1s, t_100ms, t_10ms, t_1ms;
  } time_t;
  localparam int unsigned SEC_PER_DAY  = 86400;
  localparam int unsigned SEC_PER_HOUR = 3600;
  localparam int unsigned SEC_PER_MIN  = 60;
  typedef enum logic [3:0] {
    IDLE, ADJ, D_DAY, D_HR, D_MIN, D_H10, D_M10, D_S10, DONE
  } tod_state_t;
endpackage

// File: rtl/tod_bcd_conv_divmod.sv
// seq_divmod: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (clears the divider)
//   start               - 1-cycle pulse; captures dividend and divisor
//   dividend, divisor   - W-bit unsigned operands
//   done                - 1-cycle pulse W+1 cycles after start; quot/rem valid then
//   quot, rem           - W-bit quotient and remainder
module seq_divmod #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    trial;
  logic          ge;
  // quot doubles as the dividend shift register; its MSB feeds the partial remainder
  assign trial = {rem, quot[W-1]};
  assign ge    = trial >= {1'b0, dvs_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dvs_q <= '0;
      quot  <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      done <= cnt_q == CW'(1);
      if (start) begin
        cnt_q <= CW'(W);
        dvs_q <= divisor;
        quot  <= dividend;
        rem   <= '0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        quot  <= {quot[W-2:0], ge};
        rem   <= ge ? W'(trial - {1'b0, dvs_q}) : trial[W-1:0];
      end
    end
  end
endmodule

// File: rtl/tod_bcd_conv.sv
// tod_bcd_conv: converts NTP seconds plus a signed timezone offset into a BCD time-of-day set word.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - 1-cycle request; samples sec_in and tz_off when idle
//   sec_in       - unsigned NTP seconds
//   tz_off       - signed timezone offset in seconds
//   busy         - conversion in progress (includes the set cycle)
//   set          - 1-cycle pulse when set_time is updated
//   set_time     - BCD hh:mm:ss.000, held between conversions
//   load_err     - 1-cycle pulse when load arrives while busy
module tod_bcd_conv
  import types_pkg::*;
#(
  parameter int DIV_W = 34,
  parameter int TZ_W  = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [31:0]     sec_in,
  input  logic [TZ_W-1:0] tz_off,
  output logic            busy,
  output logic            set,
  output time_t           set_time,
  output logic            load_err
);
  tod_state_t       state_q;
  logic [31:0]      sec_q;
  logic [TZ_W-1:0]  tz_q;
  logic [DIV_W-1:0] dvd_q, dvs_q, adj_raw, adj, dv_q, dv_r;
  logic             go_q, dv_done;
  logic [4:0]       hr_q;
  logic [5:0]       mn_q, sc_q;
  logic [3:0]       h10_q, h1_q, m10_q, m1_q;
  logic             unused_ok;
  assign adj_raw   = DIV_W'(sec_q) + {{(DIV_W-TZ_W){tz_q[TZ_W-1]}}, tz_q};
  // a negative sum can only come from a westward offset exceeding sec_in; wrap into the previous day
  assign adj       = adj_raw[DIV_W-1] ? adj_raw + DIV_W'(SEC_PER_DAY) : adj_raw;
  assign unused_ok = ^dv_q[DIV_W-1:6];
  seq_divmod #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (go_q),
    .dividend (dvd_q),
    .divisor  (dvs_q),
    .done     (dv_done),
    .quot     (dv_q),
    .rem      (dv_r)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sec_q    <= '0;
      tz_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      go_q     <= 1'b0;
      hr_q     <= '0;
      mn_q     <= '0;
      sc_q     <= '0;
      h10_q    <= '0;
      h1_q     <= '0;
      m10_q    <= '0;
      m1_q     <= '0;
      busy     <= 1'b0;
      set      <= 1'b0;
      set_time <= '0;
      load_err <= 1'b0;
    end else begin
      go_q     <= 1'b0;
      set      <= 1'b0;
      load_err <= load && state_q != IDLE;
      case (state_q)
        IDLE: if (load) begin
          sec_q   <= sec_in;
          tz_q    <= tz_off;
          busy    <= 1'b1;
          state_q <= ADJ;
        end
        ADJ: begin
          dvd_q   <= adj;
          dvs_q   <= DIV_W'(SEC_PER_DAY);
          go_q    <= 1'b1;
          state_q <= D_DAY;
        end
        D_DAY: if (dv_done) begin
          dvd_q   <= dv_r;
          dvs_q   <= DIV_W'(SEC_PER_HOUR);
          go_q    <= 1'b1;
          state_q <= D_HR;
        end
        D_HR: if (dv_done) begin
          hr_q    <= dv_q[4:0];
          dvd_q   <= dv_r;
          dvs_q   <= DIV_W'(SEC_PER_MIN);
          go_q    <= 1'b1;
          state_q <= D_MIN;
        end
        D_MIN: if (dv_done) begin
          mn_q    <= dv_q[5:0];
          sc_q    <= dv_r[5:0];
          dvd_q   <= DIV_W'(hr_q);
          dvs_q   <= DIV_W'(10);
          go_q    <= 1'b1;
          state_q <= D_H10;
        end
        D_H10: if (dv_done) begin
          h10_q   <= dv_q[3:0];
          h1_q    <= dv_r[3:0];
          dvd_q   <= DIV_W'(mn_q);
          go_q    <= 1'b1;
          state_q <= D_M10;
        end
        D_M10: if (dv_done) begin
          m10_q   <= dv_q[3:0];
          m1_q    <= dv_r[3:0];
          dvd_q   <= DIV_W'(sc_q);
          go_q    <= 1'b1;
          state_q <= D_S10;
        end
        D_S10: if (dv_done) begin
          set_time <= '{t_10h: h10_q, t_1h: h1_q, t_10m: m10_q, t_1m: m1_q,
                        t_10s: dv_q[3:0], t_1s: dv_r[3:0], default: 4'd0};
          set      <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tod_bcd_conv.sv
// tb_tod_bcd_conv: directed and random checks of tod_bcd_conv against an arithmetic time-of-day model.
module tb_tod_bcd_conv;
  import types_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] sec_in = '0;
  logic [17:0] tz_off = '0;
  logic        busy, set, load_err;
  time_t       set_time;
  int          errors = 0, checks = 0;
  int          lat, nerr, nset, errn;
  bit          stable;
  time_t       prev, got;

  tod_bcd_conv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .sec_in   (sec_in),
    .tz_off   (tz_off),
    .busy     (busy),
    .set      (set),
    .set_time (set_time),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic time_t ref_tod(input int unsigned s, input int tz);
    longint a, h, m, sc;
    time_t  r;
    a = longint'(s) + longint'(tz);
    if (a < 0) a += 86400;
    a  = a % 86400;
    h  = a / 3600;
    m  = (a % 3600) / 60;
    sc = a % 60;
    r  = '0;
    r.t_10h = 4'(h / 10);
    r.t_1h  = 4'(h % 10);
    r.t_10m = 4'(m / 10);
    r.t_1m  = 4'(m % 10);
    r.t_10s = 4'(sc / 10);
    r.t_1s  = 4'(sc % 10);
    return r;
  endfunction

  task automatic start(input int unsigned s, input int tz);
    load   = 1'b1;
    sec_in = s;
    tz_off = 18'(tz);
  endtask

  task automatic wait_set(output int l, output bit st);
    time_t p;
    p  = set_time;
    l  = -1;
    st = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) load = 1'b0;
      if (set) begin
        l = n;
        break;
      end
      if (set_time !== p) st = 1'b0;
    end
  endtask

  task automatic convert(input string tag, input int unsigned s, input int tz);
    int l;
    bit st;
    start(s, tz);
    wait_set(l, st);
    chk({tag, " latency"}, l, 218);
    chk({tag, " set_time"}, set_time, ref_tod(s, tz));
    chk({tag, " held"}, st, 1'b1);
    @(negedge clk);
    chk({tag, " idle"}, {busy, set}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset set", set, 1'b0);
    chk("reset load_err", load_err, 1'b0);
    chk("reset set_time", set_time, '0);
    rst_n = 1'b1;
    @(negedge clk);

    start(0, 0);
    @(negedge clk);
    load = 1'b0;
    chk("busy after load", busy, 1'b1);
    repeat (300) @(negedge clk);
    convert("T1", 0, 0);
    convert("T2a", 32'd3900000000, 0);
    convert("T2b", 32'd3900000000, -28800);
    convert("T3", 100, -3600);
    convert("T4a", 86399, 0);
    convert("T4b", 86400, 0);
    convert("T4c", 43200, 50400);
    convert("east max", 32'hFFFFFFFF, 50400);
    convert("west max", 0, -50400);

    // second load mid-conversion is rejected and does not disturb the first
    start(32'd3900000000, -28800);
    nerr = 0; nset = 0; errn = -1; lat = -1; stable = 1'b1; prev = set_time; got = '0;
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (load_err) begin nerr++; errn = n; end
      if (set) begin nset++; lat = n; got = set_time; end
      else if (nset == 0 && set_time !== prev) stable = 1'b0;
      if (n == 1 || n == 51) load = 1'b0;
      if (n == 50) start(12345, 3600);
    end
    chk("T5 load_err cycle", errn, 51);
    chk("T5 load_err count", nerr, 1);
    chk("T5 set count", nset, 1);
    chk("T5 latency", lat, 218);
    chk("T5 set_time", got, ref_tod(32'd3900000000, -28800));
    chk("T5 held", stable, 1'b1);

    // load in the set cycle is rejected; load on the following cycle is accepted
    start(5000, 0);
    wait_set(lat, stable);
    chk("done set_time", set_time, ref_tod(5000, 0));
    start(7777, 0);
    @(negedge clk);
    chk("done load_err", load_err, 1'b1);
    chk("done busy", busy, 1'b0);
    start(70000, -7200);
    wait_set(lat, stable);
    chk("after done latency", lat, 218);
    chk("after done set_time", set_time, ref_tod(70000, -7200));
    @(negedge clk);

    // reset mid-conversion aborts without a set pulse
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    start(1234567, 3600);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) load = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("T6 busy", busy, 1'b0);
    chk("T6 set_time", set_time, '0);
    @(negedge clk);
    rst_n = 1'b1;
    nset = 0;
    repeat (250) begin
      @(negedge clk);
      nset += int'(set);
    end
    chk("T6 no set", nset, 0);
    chk("T6 set_time held", set_time, '0);
    convert("T6 fresh", 1234567, 3600);

    for (int i = 0; i < 12; i++) begin
      int unsigned s;
      int          tz;
      s  = (i % 3 == 0) ? $urandom_range(60000) : $urandom;
      tz = int'($urandom_range(100800)) - 50400;
      convert($sformatf("rand%0d", i), s, tz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
